imem_uart_loader: RTL and testbench

// - Upstream boot stage for the single-cycle core: receives a program over UART (8N1) and writes it word-by-word into instruction memory.
// - Holds the core in reset (cpu_reset) until a complete, checksum-valid image is stored; then releases it.
// - A new sync byte at any time after load completes or fails restarts loading and re-asserts cpu_reset.

---
 rtl/imem_uart_loader_pkg.sv | 24 ++
 rtl/imem_uart_loader_uart_rx.sv | 87 ++++++++
 rtl/imem_uart_loader.sv | 150 +++++++++++++++
 tb/tb_imem_uart_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared types for the UART instruction-memory boot loader.
// Loader and receiver state encodings plus the frame sync byte.
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    WRITE,
    GET_CHK,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver with input synchroniser, false-start rejection
// and a one-cycle framing-error pulse.
module uart_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  rx_state_t     st;
  logic [2:0]    sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx;
  logic          bit_end;

  // sync[1] is the synchronised line, sync[2] its previous value
  assign rx      = sync[1];
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= RX_IDLE;
      sync         <= 3'b111;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[1:0], rx_serial};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (sync[2] && !rx) st <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {rx, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a checksummed program image over UART,
// writes it into instruction memory and then releases the core.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 7,
  parameter int MAX_WORDS   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_serial,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int TIMEOUT_CLKS = 20 * CLKS_PER_BIT;
  localparam int WIDX_W       = $clog2(MAX_WORDS) + 1;
  localparam int TMR_W        = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  loader_state_t     state;
  logic [WIDX_W-1:0] word_idx;
  logic [WIDX_W-1:0] n_words;
  logic [1:0]        byte_idx;
  logic [7:0]        chk;
  logic [23:0]       wbuf;
  logic [TMR_W-1:0]  timer;
  logic              loading;
  logic              abort;

  assign loading = state inside {GET_LEN, GET_DATA, GET_CHK};
  assign abort   = loading && !rx_valid &&
                   (rx_frame_err || timer == TMR_W'(TIMEOUT_CLKS - 1));

  // Write strobe and cpu_reset are registered on the transition so they
  // land exactly one cycle after the triggering rx_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_idx   <= '0;
      n_words    <= '0;
      byte_idx   <= '0;
      chk        <= '0;
      wbuf       <= '0;
      timer      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (rx_valid || !loading) timer <= '0;
      else timer <= timer + 1'b1;
      if (abort) begin
        state      <= ERROR;
        load_error <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_valid && rx_byte == SYNC_BYTE) state <= GET_LEN;
          end
          GET_LEN: begin
            if (rx_valid) begin
              chk      <= '0;
              word_idx <= '0;
              byte_idx <= '0;
              if (rx_byte == 8'd0) begin
                state <= GET_CHK;
              end else if ({24'd0, rx_byte} > 32'(MAX_WORDS)) begin
                state      <= ERROR;
                load_error <= 1'b1;
              end else begin
                n_words <= WIDX_W'(rx_byte);
                state   <= GET_DATA;
              end
            end
          end
          GET_DATA: begin
            if (rx_valid) begin
              chk      <= chk ^ rx_byte;
              byte_idx <= byte_idx + 1'b1;
              if (byte_idx == 2'd3) begin
                state      <= WRITE;
                imem_we    <= 1'b1;
                imem_addr  <= ADDR_W'({word_idx, 2'b00});
                imem_wdata <= {rx_byte, wbuf};
              end else begin
                wbuf[{byte_idx, 3'b000} +: 8] <= rx_byte;
              end
            end
          end
          WRITE: begin
            word_idx <= word_idx + 1'b1;
            state    <= (word_idx == n_words - 1'b1) ? GET_CHK : GET_DATA;
          end
          GET_CHK: begin
            if (rx_valid) begin
              if (rx_byte == chk) begin
                state     <= DONE;
                cpu_reset <= 1'b0;
                load_done <= 1'b1;
              end else begin
                state      <= ERROR;
                load_error <= 1'b1;
              end
            end
          end
          DONE: begin
            if (rx_valid && rx_byte == SYNC_BYTE) begin
              state     <= GET_LEN;
              cpu_reset <= 1'b1;
              load_done <= 1'b0;
            end
          end
          ERROR: begin
            if (rx_valid && rx_byte == SYNC_BYTE) begin
              state      <= GET_LEN;
              load_error <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: write scoreboard plus
// per-scenario status checks at 10 clocks per UART bit.
module tb_imem_uart_loader;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_serial;
  logic        imem_we;
  logic [6:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  logic [38:0] exp_q[$];
  logic        rv_d = 1'b0;
  logic        cr_d = 1'b1;

  imem_uart_loader #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000),
    .ADDR_W     (7),
    .MAX_WORDS  (32)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .rx_serial (rx_serial),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every write must match the head of the queue and
  // follow a received byte by exactly one cycle; cpu_reset edges likewise.
  always @(negedge clk) begin
    logic [38:0] e;
    if (!reset) begin
      if (imem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected got addr=%h data=%h", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({imem_addr, imem_wdata} !== e) begin
            errors++;
            $display("FAIL imem_write got addr=%h data=%h expected addr=%h data=%h",
                     imem_addr, imem_wdata, e[38:32], e[31:0]);
          end
        end
        checks++;
        if (rv_d !== 1'b1) begin
          errors++;
          $display("FAIL we_latency got rx_valid_prev=%b expected 1", rv_d);
        end
      end
      if (cpu_reset !== cr_d) begin
        checks++;
        if (rv_d !== 1'b1) begin
          errors++;
          $display("FAIL cpu_reset_latency got rx_valid_prev=%b expected 1", rv_d);
        end
      end
      if (u_dut.rx_valid) n_valid++;
    end
    rv_d = u_dut.rx_valid;
    cr_d = cpu_reset;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    rx_serial = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      wait_clks(CPB);
    end
    rx_serial = stop;
    wait_clks(CPB);
    rx_serial = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic send_frame(input int n, input logic [31:0] w0,
                            input logic [31:0] w1, input bit bad_chk);
    logic [7:0]  c;
    logic [31:0] w;
    c = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      exp_q.push_back({7'(k * 4), w});
      for (int j = 0; j < 4; j++) begin
        c ^= w[8*j +: 8];
        send_byte(w[8*j +: 8]);
      end
    end
    send_byte(bad_chk ? (c ^ 8'h01) : c);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx_serial = 1'b1;
    wait_clks(3);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error}
        !== {1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got we=%b addr=%h data=%h cr=%b ld=%b le=%b",
               imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error);
    end
    reset = 1'b0;
    wait_clks(3);
  endtask

  task automatic test_good_load;
    send_frame(2, 32'h0000_0013, 32'h0010_0093, 1'b0);
    wait_clks(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_writes got pending=%0d expected 0", exp_q.size());
    end
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b010) begin
      errors++;
      $display("FAIL good_status got %b expected 010", {cpu_reset, load_done, load_error});
    end
  endtask

  task automatic test_bad_chk;
    send_frame(2, 32'h0000_0013, 32'h0010_0093, 1'b1);
    wait_clks(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL badchk_writes got pending=%0d expected 0", exp_q.size());
    end
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b101) begin
      errors++;
      $display("FAIL badchk_status got %b expected 101", {cpu_reset, load_done, load_error});
    end
    send_frame(2, 32'h1122_3344, 32'h5566_7788, 1'b0);
    wait_clks(3);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b010) begin
      errors++;
      $display("FAIL recover_status got %b expected 010", {cpu_reset, load_done, load_error});
    end
  endtask

  task automatic test_length;
    send_byte(8'hA5);
    send_byte(8'h21);
    wait_clks(3);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b101) begin
      errors++;
      $display("FAIL too_long_status got %b expected 101", {cpu_reset, load_done, load_error});
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_clks(3);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b010) begin
      errors++;
      $display("FAIL empty_image_status got %b expected 010", {cpu_reset, load_done, load_error});
    end
  endtask

  task automatic test_framing;
    int v;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b0);
    wait_clks(3);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b101) begin
      errors++;
      $display("FAIL framing_status got %b expected 101", {cpu_reset, load_done, load_error});
    end
    v = n_valid;
    rx_serial = 1'b0;
    wait_clks(1);
    rx_serial = 1'b1;
    wait_clks(3 * CPB);
    checks++;
    if (n_valid != v) begin
      errors++;
      $display("FAIL glitch_rx got %0d bytes expected 0", n_valid - v);
    end
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b101) begin
      errors++;
      $display("FAIL glitch_status got %b expected 101", {cpu_reset, load_done, load_error});
    end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_clks(100);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b100) begin
      errors++;
      $display("FAIL before_timeout got %b expected 100", {cpu_reset, load_done, load_error});
    end
    wait_clks(150);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b101) begin
      errors++;
      $display("FAIL after_timeout got %b expected 101", {cpu_reset, load_done, load_error});
    end
  endtask

  task automatic test_reset_mid;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h13);
    rx_serial = 1'b0;
    wait_clks(CPB + 3);
    reset = 1'b1;
    rx_serial = 1'b1;
    wait_clks(2);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error}
        !== {1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values got we=%b addr=%h data=%h cr=%b ld=%b le=%b",
               imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error);
    end
    reset = 1'b0;
    wait_clks(3 * CPB);
    send_frame(2, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b0);
    wait_clks(3);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b010 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_load got %b pending=%0d expected 010 pending=0",
               {cpu_reset, load_done, load_error}, exp_q.size());
    end
  endtask

  task automatic test_reload;
    logic [31:0] w;
    logic [7:0]  c;
    w = 32'hDEAD_BEEF;
    c = 8'h00;
    send_byte(8'hA5);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b100) begin
      errors++;
      $display("FAIL resync_status got %b expected 100", {cpu_reset, load_done, load_error});
    end
    send_byte(8'h01);
    exp_q.push_back({7'd0, w});
    for (int j = 0; j < 4; j++) begin
      c ^= w[8*j +: 8];
      send_byte(w[8*j +: 8]);
    end
    send_byte(c);
    wait_clks(3);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b010 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reload_status got %b pending=%0d expected 010 pending=0",
               {cpu_reset, load_done, load_error}, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_serial = 1'b1;
    test_reset();
    test_good_load();
    test_bad_chk();
    test_length();
    test_framing();
    test_timeout();
    test_reset_mid();
    test_reload();
    wait_clks(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
